modport_core: RTL and testbench
===============================

MODPORT_CORE -- requirements
Module: modport_core

Interface
REQ-001 The module SHALL have one clock and an asynchronous, active-low reset.
REQ-002 The module SHALL have parameter DEPTH, default 64, giving FIFO depth in bytes; legal values are powers of two from 4 to 64.
REQ-003 The module SHALL have the following ports, in this order:
  - clk  input  1  sole clock; all logic rising-edge.
  - rst  input  1  async active-low reset.
  - ep_cfg  input  14  [13] enable, [12] flush, [11:0] reserved and ignored.
  - ep_din  input  8  write data.
  - ep_we  input  1  write strobe.
  - ep_re  input  1  read strobe.
  - ep_bf_en  input  1  threshold (block-fill) mode enable.
  - ep_bf_size  input  7  threshold in bytes.
  - ep_dout  output  8  registered read data.
  - ep_empty  output  1  FIFO holds 0 bytes.
  - ep_full  output  1  FIFO holds DEPTH bytes.
  - ep_avail  output  1  data-available indication.
  - ep_level  output  7  current byte count, 0..DEPTH.
  - ep_ovf  output  1  sticky overflow error.
  - ep_udf  output  1  sticky underflow error.

Function
REQ-004 A write SHALL occur on a rising edge when ep_we=1, ep_cfg[13]=1, ep_cfg[12]=0, and the FIFO is not full; the write stores ep_din at the tail.
REQ-005 A read SHALL occur on a rising edge when ep_re=1, ep_cfg[13]=1, ep_cfg[12]=0, and the FIFO is not empty; ep_dout takes the head byte at that edge (one-cycle latency).
REQ-006 ep_dout SHALL hold its last value when no read occurs.
REQ-007 Simultaneous read and write when full SHALL both succeed, leaving ep_level unchanged.
REQ-008 Simultaneous read and write when empty SHALL accept the write only, with no bypass, so ep_level becomes 1.
REQ-009 Pointers SHALL wrap modulo DEPTH.
REQ-010 ep_level SHALL be exact at all times.
REQ-011 ep_empty SHALL equal (ep_level==0), and ep_full SHALL equal (ep_level==DEPTH); both are combinational from registered state.
REQ-012 When ep_cfg[12]=1 or ep_cfg[13]=0, each rising edge SHALL clear the pointers and ep_level.
REQ-013 During flush/disable, ep_dout SHALL be unchanged and strobes SHALL be ignored.
REQ-014 Flush/disable SHALL take priority over a simultaneous read or write.
REQ-015 With ep_bf_en=0, ep_avail SHALL equal !ep_empty.
REQ-016 With ep_bf_en=1, ep_avail SHALL equal (ep_level >= T), where T = ep_bf_size clamped to the range 1..DEPTH.
REQ-017 ep_ovf SHALL set on a rising edge with ep_we=1 while enabled, not flushing, full, and with no simultaneous successful read.
REQ-018 ep_udf SHALL set on a rising edge with ep_re=1 while enabled, not flushing, and empty.
REQ-019 ep_ovf and ep_udf SHALL be cleared only by reset or flush.

Reset
REQ-020 Asserting rst low SHALL immediately clear the pointers and ep_level.
REQ-021 During reset, ep_dout SHALL be 8'h00, ep_empty=1, ep_full=0, ep_avail=0, ep_ovf=0, and ep_udf=0.
REQ-022 Deassertion of rst SHALL be sampled on clk.
REQ-023 Reset asserted mid-operation SHALL discard all FIFO contents.

Configuration
REQ-024 Macro MODPORT_CORE_ERR_EN defined SHALL enable the ep_ovf and ep_udf logic of REQ-017 to REQ-019.
REQ-025 Without MODPORT_CORE_ERR_EN, ep_ovf and ep_udf SHALL be tied 0 and no error registers SHALL exist.
REQ-026 The ports SHALL be identical in both MODPORT_CORE_ERR_EN builds.

Structure
REQ-027 Package modport_core_pkg SHALL hold the ep_cfg bit-index constants (CFG_EN=13, CFG_FLUSH=12) and the byte type for data.
REQ-028 Storage SHALL be the sub-module modport_core_ram: DEPTH x 8, one synchronous write port and one synchronous read port, with no reset on the array.
REQ-029 Pointer, level, flag and threshold logic SHALL reside in modport_core.

Verification
REQ-030 The bench SHALL cover: reset, cfg=14'h2000, write 8'hA5,8'h5A, read 2 -> ep_dout A5 then 5A one cycle after each read, ep_level 2->0, ep_empty=1.
REQ-031 The bench SHALL cover: DEPTH=64, 64 writes then one more write -> ep_full=1, ep_level=64, extra byte dropped, ep_ovf=1 (with MODPORT_CORE_ERR_EN), 0 without.
REQ-032 The bench SHALL cover: full FIFO, ep_we=ep_re=1 for one cycle -> ep_level stays 64, head byte read, new byte at tail, ep_ovf unchanged.
REQ-033 The bench SHALL cover: ep_bf_en=1, ep_bf_size=4, write 3 bytes -> ep_avail=0; 4th write -> ep_avail=1; ep_bf_size=0 -> ep_avail follows !ep_empty threshold 1.
REQ-034 The bench SHALL cover: 10 bytes stored, cfg=14'h3000 for one cycle -> ep_level=0, ep_empty=1, ep_ovf/ep_udf cleared, ep_dout unchanged.
REQ-035 The bench SHALL cover: read on empty FIFO -> ep_dout unchanged, ep_udf=1; then rst low mid-stream -> all outputs at reset values asynchronously.

Source files
------------

// File: rtl/modport_core_pkg.sv
// Shared definitions for the modport_core byte FIFO endpoint.
// Holds ep_cfg bit positions, the data byte type and a threshold helper.
package modport_core_pkg;

    localparam int CFG_W     = 14;
    localparam int CFG_EN    = 13;
    localparam int CFG_FLUSH = 12;
    localparam int LVL_W     = 7;

    typedef logic [7:0] byte_t;

    // Block-fill threshold: 0 behaves as 1, anything above depth as depth.
    function automatic logic [LVL_W-1:0] bf_thresh(
        input logic [LVL_W-1:0] size,
        input logic [LVL_W-1:0] depth
    );
        if (size == '0)
            return LVL_W'(1);
        else if (size > depth)
            return depth;
        else
            return size;
    endfunction

endpackage

// File: rtl/modport_core_ram.sv
// DEPTH x 8 storage: one synchronous write port, one synchronous read port.
// Ports: clk, rst (async active-low, output register only), we/waddr/wdata,
// re/raddr/rdata. The array itself is never reset.
module modport_core_ram
    import modport_core_pkg::*;
#(
    parameter int DEPTH = 64,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  byte_t         wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output byte_t         rdata
);

    byte_t mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we)
            mem[waddr] <= wdata;
    end

    // Read returns the pre-write contents when addresses collide,
    // which is what a full-FIFO simultaneous read/write needs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            rdata <= '0;
        else if (re)
            rdata <= mem[raddr];
    end

endmodule

// File: rtl/modport_core.sv
// Byte FIFO endpoint: pointers, level, flags, block-fill threshold, errors.
// Ports: clk, rst (async active-low), ep_cfg/ep_din/ep_we/ep_re/ep_bf_*,
// ep_dout/ep_empty/ep_full/ep_avail/ep_level/ep_ovf/ep_udf.
// Define MODPORT_CORE_ERR_EN to build the sticky ep_ovf/ep_udf registers.
module modport_core
    import modport_core_pkg::*;
#(
    parameter int DEPTH = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [CFG_W-1:0] ep_cfg,
    input  byte_t            ep_din,
    input  logic             ep_we,
    input  logic             ep_re,
    input  logic             ep_bf_en,
    input  logic [LVL_W-1:0] ep_bf_size,
    output byte_t            ep_dout,
    output logic             ep_empty,
    output logic             ep_full,
    output logic             ep_avail,
    output logic [LVL_W-1:0] ep_level,
    output logic             ep_ovf,
    output logic             ep_udf
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [LVL_W-1:0] DEPTH_L = LVL_W'(DEPTH);

    logic [AW-1:0]    wptr;
    logic [AW-1:0]    rptr;
    logic [LVL_W-1:0] level;
    logic [LVL_W-1:0] thresh;
    logic             active;
    logic             rd_ok;
    logic             wr_ok;
    logic             cfg_unused;

    assign cfg_unused = ^ep_cfg[CFG_FLUSH-1:0];

    assign active   = ep_cfg[CFG_EN] & ~ep_cfg[CFG_FLUSH];
    assign ep_empty = (level == '0);
    assign ep_full  = (level == DEPTH_L);
    assign ep_level = level;

    assign rd_ok = active & ep_re & ~ep_empty;
    // A read in the same cycle frees the slot, so a full FIFO still accepts.
    assign wr_ok = active & ep_we & (~ep_full | rd_ok);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wptr  <= '0;
            rptr  <= '0;
            level <= '0;
        end else if (!active) begin
            wptr  <= '0;
            rptr  <= '0;
            level <= '0;
        end else begin
            if (wr_ok)
                wptr <= wptr + AW'(1);
            if (rd_ok)
                rptr <= rptr + AW'(1);
            unique case ({wr_ok, rd_ok})
                2'b10:   level <= level + LVL_W'(1);
                2'b01:   level <= level - LVL_W'(1);
                default: level <= level;
            endcase
        end
    end

    assign thresh   = bf_thresh(ep_bf_size, DEPTH_L);
    assign ep_avail = ep_bf_en ? (level >= thresh) : ~ep_empty;

    modport_core_ram #(
        .DEPTH (DEPTH)
    ) u_ram (
        .clk   (clk),
        .rst   (rst),
        .we    (wr_ok),
        .waddr (wptr),
        .wdata (ep_din),
        .re    (rd_ok),
        .raddr (rptr),
        .rdata (ep_dout)
    );

`ifdef MODPORT_CORE_ERR_EN
    logic ovf_q;
    logic udf_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ovf_q <= 1'b0;
            udf_q <= 1'b0;
        end else if (!active) begin
            ovf_q <= 1'b0;
            udf_q <= 1'b0;
        end else begin
            if (ep_we & ep_full & ~rd_ok)
                ovf_q <= 1'b1;
            if (ep_re & ep_empty)
                udf_q <= 1'b1;
        end
    end

    assign ep_ovf = ovf_q;
    assign ep_udf = udf_q;
`else
    assign ep_ovf = 1'b0;
    assign ep_udf = 1'b0;
`endif

endmodule

// File: tb/tb_modport_core.sv
// Directed bench for modport_core with a queue scoreboard of FIFO bytes.
// Expected read data is pushed on accepted writes and popped on reads.
module tb_modport_core;
    import modport_core_pkg::*;

`ifdef MODPORT_CORE_ERR_EN
    localparam bit ERR = 1'b1;
`else
    localparam bit ERR = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [13:0] ep_cfg = '0;
    byte_t       ep_din = '0;
    logic        ep_we = 1'b0;
    logic        ep_re = 1'b0;
    logic        ep_bf_en = 1'b0;
    logic [6:0]  ep_bf_size = '0;
    byte_t       ep_dout;
    logic        ep_empty;
    logic        ep_full;
    logic        ep_avail;
    logic [6:0]  ep_level;
    logic        ep_ovf;
    logic        ep_udf;

    int    vectors = 0;
    int    miscompares = 0;
    byte_t q[$];
    byte_t exp_dout = '0;
    bit    exp_ovf = 1'b0;
    bit    exp_udf = 1'b0;

    modport_core #(
        .DEPTH (64)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .ep_cfg     (ep_cfg),
        .ep_din     (ep_din),
        .ep_we      (ep_we),
        .ep_re      (ep_re),
        .ep_bf_en   (ep_bf_en),
        .ep_bf_size (ep_bf_size),
        .ep_dout    (ep_dout),
        .ep_empty   (ep_empty),
        .ep_full    (ep_full),
        .ep_avail   (ep_avail),
        .ep_level   (ep_level),
        .ep_ovf     (ep_ovf),
        .ep_udf     (ep_udf)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic bit exp_avail();
        int t;
        int n;
        n = q.size();
        if (!ep_bf_en)
            return n != 0;
        t = int'(ep_bf_size);
        if (t < 1) t = 1;
        if (t > 64) t = 64;
        return n >= t;
    endfunction

    task automatic check_state(input string tag);
        check({tag, ".level"}, 32'(ep_level), 32'(q.size()));
        check({tag, ".empty"}, 32'(ep_empty), 32'(q.size() == 0));
        check({tag, ".full"},  32'(ep_full),  32'(q.size() == 64));
        check({tag, ".avail"}, 32'(ep_avail), 32'(exp_avail()));
        check({tag, ".ovf"},   32'(ep_ovf),   32'(exp_ovf));
        check({tag, ".udf"},   32'(ep_udf),   32'(exp_udf));
        check({tag, ".dout"},  32'(ep_dout),  32'(exp_dout));
    endtask

    // One clock with the given strobes; the model mirrors the FIFO rules.
    task automatic cycle(input logic we, input logic re, input byte_t din);
        bit en;
        bit full;
        bit empty;
        bit rd;
        en    = ep_cfg[CFG_EN] && !ep_cfg[CFG_FLUSH];
        full  = (q.size() == 64);
        empty = (q.size() == 0);
        rd    = en && re && !empty;
        ep_we  = we;
        ep_re  = re;
        ep_din = din;
        if (!en) begin
            q.delete();
            exp_ovf = 1'b0;
            exp_udf = 1'b0;
        end else begin
            if (ERR && we && full && !rd) exp_ovf = 1'b1;
            if (ERR && re && empty) exp_udf = 1'b1;
            if (rd) exp_dout = q.pop_front();
            if (we && (!full || rd)) q.push_back(din);
        end
        @(posedge clk);
        #1;
        ep_we = 1'b0;
        ep_re = 1'b0;
        if (rd) check("rd_dout", 32'(ep_dout), 32'(exp_dout));
    endtask

    initial begin
        // Reset state
        #12;
        check_state("reset");
        @(posedge clk);
        #1;
        rst = 1'b1;
        ep_cfg = 14'h2000;
        @(posedge clk);
        #1;
        check_state("post_reset");

        // Basic write/read
        cycle(1, 0, 8'hA5);
        cycle(1, 0, 8'h5A);
        check_state("wr2");
        cycle(0, 1, 8'h00);
        check_state("rd1");
        cycle(0, 1, 8'h00);
        check_state("rd2");

        // Fill to 64, then one extra write is dropped
        for (int i = 0; i < 64; i++)
            cycle(1, 0, byte_t'(i * 3 + 1));
        check_state("full");
        cycle(1, 0, 8'hEE);
        check_state("overfill");

        // Simultaneous read and write at full
        cycle(1, 1, 8'hC3);
        check_state("full_rw");
        for (int i = 0; i < 64; i++)
            cycle(0, 1, 8'h00);
        check("tail_byte", 32'(ep_dout), 32'h0000_00C3);
        check_state("drained");

        // Block-fill threshold
        ep_bf_en = 1'b1;
        ep_bf_size = 7'd4;
        for (int i = 0; i < 3; i++)
            cycle(1, 0, byte_t'(8'h10 + i));
        check_state("bf3");
        cycle(1, 0, 8'h13);
        check_state("bf4");
        ep_bf_size = 7'd0;
        #1;
        check_state("bf0_n4");
        for (int i = 0; i < 3; i++)
            cycle(0, 1, 8'h00);
        check_state("bf0_n1");
        cycle(0, 1, 8'h00);
        check_state("bf0_n0");
        ep_bf_size = 7'd100;
        cycle(1, 0, 8'h21);
        check_state("bf100");
        cycle(0, 1, 8'h00);
        ep_bf_en = 1'b0;

        // Underflow on empty read
        cycle(0, 1, 8'h00);
        check_state("udf");

        // Flush with 10 bytes stored; strobes ignored
        for (int i = 0; i < 10; i++)
            cycle(1, 0, byte_t'(8'h40 + i));
        check_state("ten");
        ep_cfg = 14'h3000;
        cycle(1, 1, 8'h77);
        check_state("flush");
        ep_cfg = 14'h2000;
        cycle(1, 0, 8'h99);
        cycle(0, 1, 8'h00);
        check_state("after_flush");

        // Underflow again, then async reset mid-stream
        cycle(0, 1, 8'h00);
        cycle(1, 0, 8'h31);
        cycle(1, 0, 8'h32);
        check_state("pre_rst");
        #2;
        rst = 1'b0;
        q.delete();
        exp_dout = '0;
        exp_ovf = 1'b0;
        exp_udf = 1'b0;
        #1;
        check_state("async_rst");
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        cycle(1, 0, 8'h6B);
        cycle(0, 1, 8'h00);
        check_state("post_rst");

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
